// File: rtl/dm_pkg.sv
// Shared load/store opcode definitions used by the controller and the data memory.
package dm_pkg;

    typedef enum logic [3:0] {
        LS_SW = 4'b0000,
        LS_SH = 4'b0001,
        LS_SB = 4'b0010,
        LS_LW = 4'b0011,
        LS_LH = 4'b0100,
        LS_LB = 4'b0101
    } ls_op_e;

endpackage : dm_pkg

// File: rtl/dm_load_ext.sv
// Load lane selection and sign extension for a word read from the data memory.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [3:0]  ls_op_i,
    output logic [31:0] rdata_o
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    always_comb begin
        half     = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        byte_sel = 8'h00;
        case (addr_lo_i)
            2'b00: byte_sel = word_i[7:0];
            2'b01: byte_sel = word_i[15:8];
            2'b10: byte_sel = word_i[23:16];
            2'b11: byte_sel = word_i[31:24];
            default: byte_sel = 8'h00;
        endcase
    end

    always_comb begin
        rdata_o = word_i;
        case (ls_op_i)
            LS_LW:   rdata_o = word_i;
            LS_LH:   rdata_o = {{16{half[15]}}, half};
            LS_LB:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
            // stores and reserved codes expose the raw addressed word
            default: rdata_o = word_i;
        endcase
    end

endmodule : dm_load_ext

// File: rtl/dm.sv
// Word-organised little-endian data memory with combinational loads,
// byte/half/word stores, synchronous clear and a simulation write trace.
module dm
    import dm_pkg::*;
#(
    parameter int DEPTH = 3072,
    parameter int AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        MemWrite,
    input  logic [3:0]  LSOp,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [AW-1:0] idx;
    logic        in_range;
    logic [31:0] rd_word;
    logic [31:0] wr_word_d;
    logic        we_d;

    assign idx      = addr[AW+1:2];
    assign in_range = (addr < 32'(DEPTH * 4));
    assign rd_word  = in_range ? mem_q[idx] : '0;

    dm_load_ext u_load_ext (
        .word_i    (rd_word),
        .addr_lo_i (addr[1:0]),
        .ls_op_i   (LSOp),
        .rdata_o   (rdata)
    );

    always_comb begin
        wr_word_d = rd_word;
        we_d      = 1'b0;
        case (LSOp)
            LS_SW: begin
                wr_word_d = wdata;
                we_d      = 1'b1;
            end
            LS_SH: begin
                if (addr[1]) wr_word_d[31:16] = wdata[15:0];
                else         wr_word_d[15:0]  = wdata[15:0];
                we_d = 1'b1;
            end
            LS_SB: begin
                case (addr[1:0])
                    2'b00:   wr_word_d[7:0]   = wdata[7:0];
                    2'b01:   wr_word_d[15:8]  = wdata[7:0];
                    2'b10:   wr_word_d[23:16] = wdata[7:0];
                    default: wr_word_d[31:24] = wdata[7:0];
                endcase
                we_d = 1'b1;
            end
            default: we_d = 1'b0;
        endcase
        we_d = we_d & MemWrite & in_range;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_d) begin
            mem_q[idx] <= wr_word_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && we_d) begin
            $display("@%08h: *%08h <= %08h", pc, {addr[31:2], 2'b00}, wr_word_d);
        end
    end
`endif

endmodule : dm

// File: tb/tb_dm.sv
// Randomised and directed checks of dm against a byte-array reference model.
module tb_dm;

    localparam int DEPTH = 3072;
    localparam int NBYTE = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        MemWrite;
    logic [3:0]  LSOp;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    logic [7:0] ref_mem [NBYTE];
    int n_checks = 0;
    int n_fail   = 0;

    dm #(.DEPTH(DEPTH), .AW(12)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .MemWrite (MemWrite),
        .LSOp     (LSOp),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] op);
        int base;
        logic [31:0] w;
        logic [7:0] lo, hi;
        if (a >= 32'(NBYTE)) return '0;
        base = int'(a & 32'hFFFF_FFFC);
        w = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        case (op)
            4'h4: begin
                lo = ref_mem[base + (a[1] ? 2 : 0)];
                hi = ref_mem[base + (a[1] ? 3 : 1)];
                return 32'($signed({hi, lo}));
            end
            4'h5: return 32'($signed(ref_mem[int'(a)]));
            default: return w;
        endcase
    endfunction

    function automatic void model_store(input logic we, input logic rst, input logic [3:0] op,
                                        input logic [31:0] a, input logic [31:0] d);
        int base;
        if (rst) begin
            for (int i = 0; i < NBYTE; i++) ref_mem[i] = 8'h00;
            return;
        end
        if (!we || a >= 32'(NBYTE)) return;
        base = int'(a & 32'hFFFF_FFFC);
        case (op)
            4'h0: for (int i = 0; i < 4; i++) ref_mem[base+i] = d[8*i +: 8];
            4'h1: begin
                ref_mem[base + (a[1] ? 2 : 0)] = d[7:0];
                ref_mem[base + (a[1] ? 3 : 1)] = d[15:8];
            end
            4'h2: ref_mem[int'(a)] = d[7:0];
            default: ;
        endcase
    endfunction

    task automatic cycle(input logic we, input logic rst, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        MemWrite = we; reset = rst; LSOp = op; addr = a; wdata = d; pc = p;
        @(posedge clk);
        model_store(we, rst, op, a, d);
        #1;
        MemWrite = 1'b0; reset = 1'b0;
    endtask

    task automatic read_at(input logic [3:0] op, input logic [31:0] a);
        LSOp = op; addr = a; MemWrite = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        cycle(1'b0, 1'b1, 4'h3, 32'h0, 32'h0, 32'h0);
        read_at(4'h3, 32'h10);
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_lw10: got %08h want %08h", rdata, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, NBYTE - 1));
            read_at(4'h3, a);
            n_checks++;
            if (rdata !== 32'h0) begin
                n_fail++; $display("FAIL reset_clear @%08h: got %08h want 0", a, rdata);
            end
        end
    endtask

    task automatic test_sw_loads;
        cycle(1'b1, 1'b0, 4'h0, 32'h4, 32'h8765_4321, 32'h0000_3000);
        read_at(4'h3, 32'h4);
        n_checks++;
        if (rdata !== 32'h8765_4321) begin
            n_fail++; $display("FAIL sw_lw: got %08h want 87654321", rdata);
        end
        read_at(4'h3, 32'h7);
        n_checks++;
        if (rdata !== 32'h8765_4321) begin
            n_fail++; $display("FAIL lw_unaligned: got %08h want 87654321", rdata);
        end
        read_at(4'h4, 32'h6);
        n_checks++;
        if (rdata !== 32'hFFFF_8765) begin
            n_fail++; $display("FAIL lh6: got %08h want ffff8765", rdata);
        end
        read_at(4'h5, 32'h7);
        n_checks++;
        if (rdata !== 32'hFFFF_FF87) begin
            n_fail++; $display("FAIL lb7: got %08h want ffffff87", rdata);
        end
        read_at(4'h5, 32'h4);
        n_checks++;
        if (rdata !== 32'h0000_0021) begin
            n_fail++; $display("FAIL lb4: got %08h want 00000021", rdata);
        end
    endtask

    task automatic test_partial_stores;
        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h1122_3344, 32'h100);
        cycle(1'b1, 1'b0, 4'h2, 32'h2, 32'hFFFF_FFAB, 32'h104);
        read_at(4'h3, 32'h0);
        n_checks++;
        if (rdata !== 32'h11AB_3344) begin
            n_fail++; $display("FAIL sb2: got %08h want 11ab3344", rdata);
        end
        cycle(1'b1, 1'b0, 4'h1, 32'h1, 32'hAAAA_7FEE, 32'h108);
        read_at(4'h3, 32'h0);
        n_checks++;
        if (rdata !== 32'h11AB_7FEE) begin
            n_fail++; $display("FAIL sh0: got %08h want 11ab7fee", rdata);
        end
        read_at(4'h4, 32'h0);
        n_checks++;
        if (rdata !== 32'h0000_7FEE) begin
            n_fail++; $display("FAIL lh0: got %08h want 00007fee", rdata);
        end
    endtask

    task automatic test_out_of_range;
        cycle(1'b1, 1'b0, 4'h0, 32'h3000, 32'hDEAD_BEEF, 32'h200);
        read_at(4'h3, 32'h0);
        n_checks++;
        if (rdata !== 32'h11AB_7FEE) begin
            n_fail++; $display("FAIL oor_word0: got %08h want 11ab7fee", rdata);
        end
        read_at(4'h3, 32'h3000);
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++; $display("FAIL oor_read: got %08h want 0", rdata);
        end
        cycle(1'b1, 1'b0, 4'h0, 32'h2FFC, 32'hC0FF_EE01, 32'h204);
        read_at(4'h5, 32'h2FFF);
        n_checks++;
        if (rdata !== 32'hFFFF_FFC0) begin
            n_fail++; $display("FAIL top_lb: got %08h want ffffffc0", rdata);
        end
    endtask

    task automatic test_reset_collision;
        cycle(1'b1, 1'b0, 4'h0, 32'h20, 32'h1234_5678, 32'h300);
        cycle(1'b1, 1'b1, 4'h0, 32'h8, 32'h5, 32'h304);
        read_at(4'h3, 32'h8);
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_collide: got %08h want 0", rdata);
        end
        cycle(1'b1, 1'b0, 4'h0, 32'h24, 32'h9999_9999, 32'h308);
        read_at(4'h3, 32'h20);
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_between: got %08h want 0", rdata);
        end
    endtask

    task automatic test_load_nowrite;
        cycle(1'b1, 1'b0, 4'h0, 32'h30, 32'hA5A5_A5A5, 32'h400);
        cycle(1'b1, 1'b0, 4'h3, 32'h30, 32'h0000_0000, 32'h404);
        cycle(1'b1, 1'b0, 4'h7, 32'h30, 32'h0000_0000, 32'h408);
        read_at(4'h3, 32'h30);
        n_checks++;
        if (rdata !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL load_nowrite: got %08h want a5a5a5a5", rdata);
        end
        read_at(4'h6, 32'h33);
        n_checks++;
        if (rdata !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL reserved_raw: got %08h want a5a5a5a5", rdata);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, d, exp;
            logic [3:0]  op;
            logic        we;
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r < 7)      a = 32'($urandom_range(0, 63));
            else if (r < 9) a = 32'h2FF0 + 32'($urandom_range(0, 31));
            else            a = $urandom;
            op = 4'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            MemWrite = we; reset = 1'b0; LSOp = op; addr = a; wdata = d; pc = 32'h1000 + 32'(n);
            #1;
            exp = model_load(a, op);
            n_checks++;
            if (rdata !== exp) begin
                n_fail++; $display("FAIL rnd_pre #%0d op%0h @%08h: got %08h want %08h", n, op, a, rdata, exp);
            end
            @(posedge clk);
            model_store(we, 1'b0, op, a, d);
            #1;
            exp = model_load(a, op);
            n_checks++;
            if (rdata !== exp) begin
                n_fail++; $display("FAIL rnd_post #%0d op%0h @%08h: got %08h want %08h", n, op, a, rdata, exp);
            end
        end
        MemWrite = 1'b0;
    endtask

    initial begin
        reset = 1'b0; MemWrite = 1'b0; LSOp = 4'h3; addr = '0; wdata = '0; pc = '0;
        for (int i = 0; i < NBYTE; i++) ref_mem[i] = 8'h00;
        @(posedge clk); #1;
        test_reset();
        test_sw_loads();
        test_partial_stores();
        test_out_of_range();
        test_reset_collision();
        test_load_nowrite();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dm

// File: doc/dm.md
DM -- requirements
Module: dm

Interface
REQ-001 Parameter DEPTH, default 3072, number of 32-bit words in the data memory (byte range 0x0000_0000-0x0000_2FFF).
REQ-002 Parameter AW, default 12, word-index width; SHALL satisfy 2^AW >= DEPTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc  input  32  PC of the instruction in flight; used only for the write trace.
REQ-006 MemWrite  input  1  store enable from the controller.
REQ-007 LSOp  input  4  access type: 0000 sw, 0001 sh, 0010 sb, 0011 lw, 0100 lh, 0101 lb; other codes are reserved.
REQ-008 addr  input  32  byte address from the ALU.
REQ-009 wdata  input  32  store data (rt value); the low byte or low half is used for sb/sh.
REQ-010 rdata  output  32  load result, already extended, routed to the register-file write mux.

Function
REQ-011 Storage SHALL be DEPTH words, indexed by addr[AW+1:2], in little-endian byte order: addr[1:0]=00 selects bits [7:0].
REQ-012 Reads SHALL be combinational (zero latency): rdata follows addr/LSOp within the same cycle.
REQ-013 lw SHALL return the full word; addr[1:0] SHALL be ignored.
REQ-014 lh SHALL return the sign-extended half selected by addr[1] (0 selects [15:0], 1 selects [31:16]); addr[0] SHALL be ignored.
REQ-015 lb SHALL return the sign-extended byte selected by addr[1:0].
REQ-016 Store LSOp codes and reserved codes SHALL return the raw addressed word on rdata.
REQ-017 A write SHALL occur on a rising clk edge only when MemWrite=1 and reset=0.
REQ-018 sw SHALL replace the whole word.
REQ-019 sh SHALL replace only the half selected by addr[1] with wdata[15:0].
REQ-020 sb SHALL replace only the byte selected by addr[1:0] with wdata[7:0].
REQ-021 Unselected lanes SHALL keep their prior value.
REQ-022 MemWrite=1 with a load or reserved LSOp SHALL write nothing.
REQ-023 Out-of-range address (addr >= DEPTH*4): writes SHALL be dropped, reads SHALL return 0, and no trace line SHALL be printed.
REQ-024 Read and write to the same word in the same cycle: rdata SHALL show the old value before the edge and the new value after it. There is no bypass.
REQ-025 Each effective write SHALL print exactly one line: "@<pc 8 hex>: *<word-aligned addr 8 hex> <= <merged 32-bit word 8 hex>". Simulation only; the line SHALL show the post-merge full word.

Reset
REQ-026 When reset=1 at a rising edge, every memory word SHALL become 0x0000_0000 and any concurrent write SHALL be suppressed.
REQ-027 After reset, rdata SHALL be 0 for any in-range address until a write occurs.
REQ-028 A reset asserted between two stores SHALL leave no trace of the earlier store.

Structure
REQ-029 The LSOp encodings (SW, SH, SB, LW, LH, LB) SHALL live in a shared definitions header that both the controller and dm include; they SHALL NOT be literals inside dm.
REQ-030 Load lane-select and extension SHALL be one combinational sub-module, dm_load_ext (inputs: word, addr[1:0], LSOp; output: rdata).
REQ-031 Store byte-lane merge SHALL remain inside dm.

Verification
REQ-032 Reset, then lw at 0x0000_0010 -> rdata=0x0000_0000.
REQ-033 sw 0x8765_4321 @0x0000_0004 with pc=0x0000_3000, then lw/lh/lb at 0x4, 0x6, 0x7:
- lw -> 0x8765_4321
- lh at 0x6 -> 0xFFFF_8765
- lb at 0x7 -> 0xFFFF_FF87
- trace line "@00003000: *00000004 <= 87654321"
REQ-034 From word 0 = 0x1122_3344:
- sb 0xAB @0x2 -> word 0x11AB_3344
- then sh 0x7FEE @0x0 -> word 0x11AB_7FEE
- lh at 0x0 -> 0x0000_7FEE
REQ-035 sw 0xDEAD_BEEF @0x0000_3000 (out of range) -> no trace, word 0 unchanged, lw @0x3000 -> 0.
REQ-036 Same cycle: MemWrite=1 with sw 0x5 @0x8, and reset=1 -> word 0x8 reads 0 after the edge, no trace.
REQ-037 MemWrite=1 with LSOp=0011 -> memory unchanged, no trace.
